mod_memstage: RTL and testbench

- Memory-access stage between execute and mod_writeback; consumes the execute result bundle and produces the EX_WB bundle plus the store-active flag that writeback uses.
- Loads (MOV r,m; POP; RETQ) and stores (MOV m,r; PUSH; CALL) go through a single-outstanding request/response memory port.
- All other opcodes pass through with one cycle of latency.
- Stalls execute while a memory access is in flight.

---
 rtl/mod_memstage_if.sv | 33 +++
 rtl/mod_memstage.sv | 184 ++++++++++++++++++
 tb/tb_mod_memstage.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_memstage_if.sv
// rtl/mod_memstage_if.sv - single-outstanding memory request/response port
interface mod_memstage_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_write,
        output mem_req_addr,
        output mem_req_wdata,
        input  mem_resp_valid,
        input  mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_write,
        input  mem_req_addr,
        input  mem_req_wdata,
        output mem_resp_valid,
        output mem_resp_rdata
    );
endinterface

// File: rtl/mod_memstage.sv
// rtl/mod_memstage.sv - memory-access stage between execute and writeback
module mod_memstage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [63:0]       ex_pc,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_alu_ext_result,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [7:0]        ex_opcode,
    input  logic [3:0]        ex_regByte,
    input  logic [3:0]        ex_rmByte,
    input  logic              ex_sim_end,
    mod_memstage_if.master    mem,
    output logic              wb_valid,
    output logic [63:0]       wb_pc,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_alu_ext_result,
    output logic [7:0]        wb_opcode,
    output logic [3:0]        wb_regByte,
    output logic [3:0]        wb_rmByte,
    output logic              wb_sim_end,
    output logic              store_memstage_active,
    output logic [CNT_W-1:0]  mem_stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state;
    logic              halted;
    logic              accept;
    logic              is_load;
    logic              is_store;

    logic [63:0]       h_pc;
    logic [DATA_W-1:0] h_alu;
    logic [DATA_W-1:0] h_ext;
    logic [7:0]        h_opcode;
    logic [3:0]        h_reg;
    logic [3:0]        h_rm;
    logic              h_sim_end;
    logic              h_store;

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Opcode classification: loads are MOV r,m / POP / RETQ, stores are MOV m,r / PUSH / CALL
    always_comb begin
        is_load  = (ex_opcode == 8'd139) ||
                   ((ex_opcode >= 8'd88) && (ex_opcode <= 8'd95)) ||
                   (ex_opcode == 8'd195);
        is_store = (ex_opcode == 8'd137) ||
                   ((ex_opcode >= 8'd80) && (ex_opcode <= 8'd87)) ||
                   (ex_opcode == 8'd232) || (ex_opcode == 8'd255);
    end

    // Ready only in IDLE, held low during reset and once a sim_end bundle has been taken
    assign ex_ready = reset && (state == IDLE) && !halted;
    assign accept   = ex_valid && ex_ready;

    assign mem.mem_req_valid = req_valid;
    assign mem.mem_req_write = req_write;
    assign mem.mem_req_addr  = req_addr;
    assign mem.mem_req_wdata = req_wdata;

    // Main stage FSM: capture, issue one request, retire one bundle per access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            halted                <= 1'b0;
            h_pc                  <= '0;
            h_alu                 <= '0;
            h_ext                 <= '0;
            h_opcode              <= '0;
            h_reg                 <= '0;
            h_rm                  <= '0;
            h_sim_end             <= 1'b0;
            h_store               <= 1'b0;
            req_valid             <= 1'b0;
            req_write             <= 1'b0;
            req_addr              <= '0;
            req_wdata             <= '0;
            wb_valid              <= 1'b0;
            wb_pc                 <= '0;
            wb_alu_result         <= '0;
            wb_alu_ext_result     <= '0;
            wb_opcode             <= '0;
            wb_regByte            <= '0;
            wb_rmByte             <= '0;
            wb_sim_end            <= 1'b0;
            store_memstage_active <= 1'b0;
        end else begin
            wb_valid              <= 1'b0;
            store_memstage_active <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        h_pc      <= ex_pc;
                        h_alu     <= ex_alu_result;
                        h_ext     <= ex_alu_ext_result;
                        h_opcode  <= ex_opcode;
                        h_reg     <= ex_regByte;
                        h_rm      <= ex_rmByte;
                        h_sim_end <= ex_sim_end;
                        h_store   <= is_store;
                        if (ex_sim_end) begin
                            halted <= 1'b1;
                        end
                        if (is_load || is_store) begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_write <= is_store;
                            req_addr  <= ex_mem_addr;
                            req_wdata <= is_store ? ex_store_data : '0;
                        end else begin
                            wb_valid          <= 1'b1;
                            wb_pc             <= ex_pc;
                            wb_alu_result     <= ex_alu_result;
                            wb_alu_ext_result <= ex_alu_ext_result;
                            wb_opcode         <= ex_opcode;
                            wb_regByte        <= ex_regByte;
                            wb_rmByte         <= ex_rmByte;
                            wb_sim_end        <= ex_sim_end;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_req_ready) begin
                        req_valid <= 1'b0;
                        if (h_store) begin
                            // Stores are posted: retire as soon as the request is taken
                            state                 <= IDLE;
                            wb_valid              <= 1'b1;
                            store_memstage_active <= 1'b1;
                            wb_pc                 <= h_pc;
                            wb_alu_result         <= h_alu;
                            wb_alu_ext_result     <= h_ext;
                            wb_opcode             <= h_opcode;
                            wb_regByte            <= h_reg;
                            wb_rmByte             <= h_rm;
                            wb_sim_end            <= h_sim_end;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_resp_valid) begin
                        state             <= IDLE;
                        wb_valid          <= 1'b1;
                        wb_pc             <= h_pc;
                        wb_alu_result     <= mem.mem_resp_rdata;
                        wb_alu_ext_result <= h_ext;
                        wb_opcode         <= h_opcode;
                        wb_regByte        <= h_reg;
                        wb_rmByte         <= h_rm;
                        wb_sim_end        <= h_sim_end;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles in which execute is held off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_stall_cycles <= '0;
        end else if (!ex_ready && (mem_stall_cycles != {CNT_W{1'b1}})) begin
            mem_stall_cycles <= mem_stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_memstage.sv
// tb/tb_mod_memstage.sv - scoreboard testbench for mod_memstage
module tb_mod_memstage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_pc;
    logic [63:0] ex_alu_result;
    logic [63:0] ex_alu_ext_result;
    logic [63:0] ex_mem_addr;
    logic [63:0] ex_store_data;
    logic [7:0]  ex_opcode;
    logic [3:0]  ex_regByte;
    logic [3:0]  ex_rmByte;
    logic        ex_sim_end;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [63:0] wb_alu_result;
    logic [63:0] wb_alu_ext_result;
    logic [7:0]  wb_opcode;
    logic [3:0]  wb_regByte;
    logic [3:0]  wb_rmByte;
    logic        wb_sim_end;
    logic        store_memstage_active;
    logic [31:0] mem_stall_cycles;

    mod_memstage_if #(.ADDR_W(64), .DATA_W(64)) mif ();

    mod_memstage #(.ADDR_W(64), .DATA_W(64), .CNT_W(32)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ex_valid              (ex_valid),
        .ex_ready              (ex_ready),
        .ex_pc                 (ex_pc),
        .ex_alu_result         (ex_alu_result),
        .ex_alu_ext_result     (ex_alu_ext_result),
        .ex_mem_addr           (ex_mem_addr),
        .ex_store_data         (ex_store_data),
        .ex_opcode             (ex_opcode),
        .ex_regByte            (ex_regByte),
        .ex_rmByte             (ex_rmByte),
        .ex_sim_end            (ex_sim_end),
        .mem                   (mif),
        .wb_valid              (wb_valid),
        .wb_pc                 (wb_pc),
        .wb_alu_result         (wb_alu_result),
        .wb_alu_ext_result     (wb_alu_ext_result),
        .wb_opcode             (wb_opcode),
        .wb_regByte            (wb_regByte),
        .wb_rmByte             (wb_rmByte),
        .wb_sim_end            (wb_sim_end),
        .store_memstage_active (store_memstage_active),
        .mem_stall_cycles      (mem_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] ext;
        logic [7:0]  op;
        logic [3:0]  rb;
        logic [3:0]  rm;
        logic        se;
        logic        st;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  wb_seen  = 0;

    function automatic wb_t mk(input logic [7:0] op, input logic [63:0] alu_in,
                               input logic [63:0] result, input logic [3:0] rb,
                               input logic se, input logic st);
        wb_t e;
        e.pc  = alu_in + 64'h100;
        e.alu = result;
        e.ext = alu_in ^ 64'hF0F0;
        e.op  = op;
        e.rb  = rb;
        e.rm  = rb ^ 4'hF;
        e.se  = se;
        e.st  = st;
        return e;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [63:0] alu, input logic [63:0] addr,
                         input logic [63:0] sd, input logic [3:0] rb, input logic se);
        ex_valid          = 1'b1;
        ex_opcode         = op;
        ex_alu_result     = alu;
        ex_alu_ext_result = alu ^ 64'hF0F0;
        ex_pc             = alu + 64'h100;
        ex_mem_addr       = addr;
        ex_store_data     = sd;
        ex_regByte        = rb;
        ex_rmByte         = rb ^ 4'hF;
        ex_sim_end        = se;
    endtask

    // Scoreboard: every retired bundle must match the oldest expectation
    always @(negedge clk) begin
        if (reset === 1'b1 && wb_valid === 1'b1) begin
            wb_t got;
            wb_t e;
            got = {wb_pc, wb_alu_result, wb_alu_ext_result, wb_opcode, wb_regByte,
                   wb_rmByte, wb_sim_end, store_memstage_active};
            n_checks++;
            wb_seen++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got %h required no bundle", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL wb_bundle: got %h required %h", got, e);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ex_ready, wb_valid, store_memstage_active, mif.mem_req_valid, mif.mem_req_write} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000",
                     {ex_ready, wb_valid, store_memstage_active, mif.mem_req_valid, mif.mem_req_write});
        end
        n_checks++;
        if ({mif.mem_req_addr, mif.mem_req_wdata, wb_alu_result, wb_pc, mem_stall_cycles} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h alu %h pc %h stall %0d required all 0",
                     mif.mem_req_addr, mif.mem_req_wdata, wb_alu_result, wb_pc, mem_stall_cycles);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", ex_ready);
        end
    endtask

    task automatic test_pass_stream();
        int   start = wb_seen;
        logic req_seen = 1'b0;
        logic [2:0] wbv;
        for (int i = 1; i <= 3; i++) begin
            drive(8'h01, 64'(i), 64'h0, 64'h0, 4'(i), 1'b0);
            exp_q.push_back(mk(8'h01, 64'(i), 64'(i), 4'(i), 1'b0, 1'b0));
            @(negedge clk);
            wbv[i-1] = wb_valid;
            req_seen = req_seen | mif.mem_req_valid;
        end
        ex_valid = 1'b0;
        @(negedge clk);
        req_seen = req_seen | mif.mem_req_valid;
        n_checks++;
        if (wbv !== 3'b111 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_wb_timing: got %b/%b required 111/0", wbv, wb_valid);
        end
        n_checks++;
        if (req_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_no_req: got %b required 0", req_seen);
        end
        n_checks++;
        if (mem_stall_cycles !== 32'd0 || wb_seen != start + 3) begin
            n_fail++;
            $display("FAIL pass_stall_count: stall %0d retired %0d required 0 and 3",
                     mem_stall_cycles, wb_seen - start);
        end
    endtask

    task automatic test_load();
        int   start = wb_seen;
        logic ready_low = 1'b0;
        drive(8'd139, 64'h55, 64'h1000, 64'h77, 4'd3, 1'b0);
        exp_q.push_back(mk(8'd139, 64'h55, 64'hDEADBEEF, 4'd3, 1'b0, 1'b0));
        @(negedge clk);
        ex_valid = 1'b0;
        n_checks++;
        if ({mif.mem_req_valid, mif.mem_req_write} !== 2'b10 || mif.mem_req_addr !== 64'h1000
            || mif.mem_req_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL load_req: valid %b write %b addr %h wdata %h required 1 0 1000 0",
                     mif.mem_req_valid, mif.mem_req_write, mif.mem_req_addr, mif.mem_req_wdata);
        end
        ready_low = ready_low | ex_ready;
        mif.mem_req_ready = 1'b1;
        @(negedge clk);
        mif.mem_req_ready = 1'b0;
        ready_low = ready_low | ex_ready;
        n_checks++;
        if (mif.mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_req_drop: got %b required 0", mif.mem_req_valid);
        end
        @(negedge clk);
        ready_low = ready_low | ex_ready;
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_rdata = 64'hDEADBEEF;
        @(negedge clk);
        mif.mem_resp_valid = 1'b0;
        n_checks++;
        if (ready_low !== 1'b0 || ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready: busy-high %b final %b required 0 and 1", ready_low, ex_ready);
        end
        @(negedge clk);
        n_checks++;
        if (wb_seen != start + 1) begin
            n_fail++;
            $display("FAIL load_retired: got %0d required 1", wb_seen - start);
        end
    endtask

    task automatic test_store_backpressure();
        logic [31:0] base;
        logic        unstable = 1'b0;
        base = mem_stall_cycles;
        drive(8'h50, 64'h9, 64'h7FF8, 64'h42, 4'd5, 1'b0);
        exp_q.push_back(mk(8'h50, 64'h9, 64'h9, 4'd5, 1'b0, 1'b1));
        @(negedge clk);
        ex_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (mif.mem_req_valid !== 1'b1 || mif.mem_req_write !== 1'b1 ||
                mif.mem_req_addr !== 64'h7FF8 || mif.mem_req_wdata !== 64'h42)
                unstable = 1'b1;
            mif.mem_req_ready = (c == 5);
            @(negedge clk);
        end
        mif.mem_req_ready = 1'b0;
        n_checks++;
        if (unstable !== 1'b0) begin
            n_fail++;
            $display("FAIL store_req_stable: got unstable=%b required 0", unstable);
        end
        n_checks++;
        if (wb_valid !== 1'b1 || store_memstage_active !== 1'b1) begin
            n_fail++;
            $display("FAIL store_retire: wb_valid %b active %b required 1 1", wb_valid, store_memstage_active);
        end
        n_checks++;
        if (mem_stall_cycles !== base + 32'd6) begin
            n_fail++;
            $display("FAIL store_stall_count: got %0d required %0d", mem_stall_cycles, base + 32'd6);
        end
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0 || store_memstage_active !== 1'b0 || mif.mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_pulse: wb_valid %b active %b req %b required 0 0 0",
                     wb_valid, store_memstage_active, mif.mem_req_valid);
        end
    endtask

    task automatic test_classify();
        logic [7:0] ops[10]   = '{8'd195, 8'd232, 8'd255, 8'd137, 8'd88, 8'd95,
                                  8'd87, 8'd80, 8'd96, 8'd79};
        int         kinds[10] = '{1, 2, 2, 2, 1, 1, 2, 2, 0, 0};
        for (int i = 0; i < 10; i++) begin
            logic [63:0] addr  = 64'h2000 + 64'(i * 8);
            logic [63:0] rdata = 64'hA000 + 64'(i);
            logic [63:0] alu   = 64'h300 + 64'(i);
            int          bound;
            drive(ops[i], alu, addr, 64'h600 + 64'(i), 4'(i), 1'b0);
            exp_q.push_back(mk(ops[i], alu, (kinds[i] == 1) ? rdata : alu, 4'(i), 1'b0,
                               kinds[i] == 2));
            @(negedge clk);
            ex_valid = 1'b0;
            n_checks++;
            if (mif.mem_req_valid !== (kinds[i] != 0) ||
                (kinds[i] != 0 && (mif.mem_req_write !== (kinds[i] == 2) || mif.mem_req_addr !== addr))) begin
                n_fail++;
                $display("FAIL classify_op%0d: valid %b write %b addr %h required kind %0d addr %h",
                         ops[i], mif.mem_req_valid, mif.mem_req_write, mif.mem_req_addr, kinds[i], addr);
            end
            mif.mem_req_ready = 1'b1;
            @(negedge clk);
            mif.mem_req_ready = 1'b0;
            if (kinds[i] == 1) begin
                mif.mem_resp_valid = 1'b1;
                mif.mem_resp_rdata = rdata;
                @(negedge clk);
                mif.mem_resp_valid = 1'b0;
            end
            bound = 0;
            while (ex_ready !== 1'b1 && bound < 10) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 10) begin
                n_checks++;
                n_fail++;
                $display("FAIL classify_timeout: op %0d ex_ready %b required 1", ops[i], ex_ready);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        drive(8'd139, 64'h11, 64'h4000, 64'h0, 4'd2, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        mif.mem_req_ready = 1'b1;
        @(negedge clk);
        mif.mem_req_ready = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ex_ready, wb_valid, mif.mem_req_valid, mif.mem_req_write} !== 4'b0 ||
            mif.mem_req_addr !== 64'h0 || mem_stall_cycles !== 32'h0 || wb_alu_result !== 64'h0) begin
            n_fail++;
            $display("FAIL midwait_reset: ready %b wb %b req %b addr %h stall %0d alu %h required all 0",
                     ex_ready, wb_valid, mif.mem_req_valid, mif.mem_req_addr, mem_stall_cycles, wb_alu_result);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mif.mem_resp_valid = 1'b1;
        mif.mem_resp_rdata = 64'hBAD0BAD0;
        @(negedge clk);
        mif.mem_resp_valid = 1'b0;
        n_checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_resp: wb_valid %b ex_ready %b required 0 1", wb_valid, ex_ready);
        end
        drive(8'h03, 64'h77, 64'h0, 64'h0, 4'd6, 1'b0);
        exp_q.push_back(mk(8'h03, 64'h77, 64'h77, 4'd6, 1'b0, 1'b0));
        @(negedge clk);
        ex_valid = 1'b0;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_alu_result !== 64'h77) begin
            n_fail++;
            $display("FAIL post_reset_pass: wb_valid %b alu %h required 1 77", wb_valid, wb_alu_result);
        end
        @(negedge clk);
    endtask

    task automatic test_sim_end();
        logic ready_seen = 1'b0;
        drive(8'h01, 64'h99, 64'h0, 64'h0, 4'd9, 1'b1);
        exp_q.push_back(mk(8'h01, 64'h99, 64'h99, 4'd9, 1'b1, 1'b0));
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b1 || wb_sim_end !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_end_wb: wb_valid %b sim_end %b required 1 1", wb_valid, wb_sim_end);
        end
        drive(8'h02, 64'hAA, 64'h0, 64'h0, 4'd1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            ready_seen = ready_seen | ex_ready;
            @(negedge clk);
        end
        ex_valid = 1'b0;
        n_checks++;
        if (ready_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_end_halt: ex_ready seen %b required 0", ready_seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b0;
        ex_valid           = 1'b0;
        ex_pc              = '0;
        ex_alu_result      = '0;
        ex_alu_ext_result  = '0;
        ex_mem_addr        = '0;
        ex_store_data      = '0;
        ex_opcode          = '0;
        ex_regByte         = '0;
        ex_rmByte          = '0;
        ex_sim_end         = 1'b0;
        mif.mem_req_ready  = 1'b0;
        mif.mem_resp_valid = 1'b0;
        mif.mem_resp_rdata = '0;

        test_reset();
        test_pass_stream();
        test_load();
        test_store_backpressure();
        test_classify();
        test_reset_mid_wait();
        test_sim_end();

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
